// File: rtl/fp_mul_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_normalize_round
// Brief    : Normalize, round-to-nearest-even and pack stage of the binary32
//            multiplier; 2-stage valid/ready pipeline with full back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_normalize_round #(
    parameter int MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*MANT_W-1:0]   prod_in,
    input  logic                  sign_in,
    input  logic [9:0]            exp_sum_in,
    input  logic                  nan_in,
    input  logic                  inf_in,
    input  logic                  zero_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           result_out,
    output logic                  overflow_out,
    output logic                  underflow_out,
    output logic                  inexact_out
);

    localparam int PROD_W = 2 * MANT_W;
    localparam int FRAC_W = MANT_W - 1;

    logic                     s1_valid_q,  s1_valid_d;
    logic [FRAC_W-1:0]        s1_mant_q,   s1_mant_d;
    logic                     s1_guard_q,  s1_guard_d;
    logic                     s1_sticky_q, s1_sticky_d;
    logic signed [9:0]        s1_exp_q,    s1_exp_d;
    logic                     s1_sign_q,   s1_sign_d;
    logic                     s1_nan_q,    s1_nan_d;
    logic                     s1_inf_q,    s1_inf_d;
    logic                     s1_zero_q,   s1_zero_d;

    logic                     s2_valid_q,  s2_valid_d;
    logic [31:0]              s2_result_q, s2_result_d;
    logic                     s2_ovf_q,    s2_ovf_d;
    logic                     s2_unf_q,    s2_unf_d;
    logic                     s2_inx_q,    s2_inx_d;

    logic                     s1_load;
    logic                     s2_adv;
    logic                     round_up;
    logic [FRAC_W:0]          mant_sum;
    logic signed [9:0]        exp_r;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_exp_d    = s1_exp_q;
        s1_sign_d   = s1_sign_q;
        s1_nan_d    = s1_nan_q;
        s1_inf_d    = s1_inf_q;
        s1_zero_d   = s1_zero_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = sign_in;
            s1_nan_d   = nan_in;
            s1_inf_d   = inf_in;
            s1_zero_d  = zero_in;
            // Product in [2,4) shifts one place further and bumps the exponent.
            if (prod_in[PROD_W-1]) begin
                s1_mant_d   = prod_in[PROD_W-2 -: FRAC_W];
                s1_guard_d  = prod_in[MANT_W-1];
                s1_sticky_d = |prod_in[MANT_W-2:0];
                s1_exp_d    = exp_sum_in + 10'd1;
            end else begin
                s1_mant_d   = prod_in[PROD_W-3 -: FRAC_W];
                s1_guard_d  = prod_in[MANT_W-2];
                s1_sticky_d = |prod_in[MANT_W-3:0];
                s1_exp_d    = exp_sum_in;
            end
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        round_up    = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
        // On carry-out the low bits of the sum are already zero.
        mant_sum    = {1'b0, s1_mant_q} + {{FRAC_W{1'b0}}, round_up};
        exp_r       = s1_exp_q + {9'd0, mant_sum[FRAC_W]};
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_ovf_d    = s2_ovf_q;
        s2_unf_d    = s2_unf_q;
        s2_inx_d    = s2_inx_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_ovf_d   = 1'b0;
            s2_unf_d   = 1'b0;
            s2_inx_d   = 1'b0;
            if (s1_nan_q) begin
                s2_result_d = 32'h7FC0_0000;
            end else if (s1_inf_q) begin
                s2_result_d = {s1_sign_q, 8'hFF, 23'h0};
            end else if (s1_zero_q) begin
                s2_result_d = {s1_sign_q, 31'h0};
            end else if (exp_r >= 10'sd255) begin
                s2_result_d = {s1_sign_q, 8'hFF, 23'h0};
                s2_ovf_d    = 1'b1;
                s2_inx_d    = 1'b1;
            end else if (exp_r <= 10'sd0) begin
                s2_result_d = {s1_sign_q, 31'h0};
                s2_unf_d    = 1'b1;
                s2_inx_d    = 1'b1;
            end else begin
                s2_result_d = {s1_sign_q, exp_r[7:0], mant_sum[FRAC_W-1:0]};
                s2_inx_d    = s1_guard_q || s1_sticky_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mant_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_sign_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
            s2_inx_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mant_q   <= s1_mant_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_exp_q    <= s1_exp_d;
            s1_sign_q   <= s1_sign_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_unf_q    <= s2_unf_d;
            s2_inx_q    <= s2_inx_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign result_out    = s2_result_q;
    assign overflow_out  = s2_ovf_q;
    assign underflow_out = s2_unf_q;
    assign inexact_out   = s2_inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_normalize_round
// Brief    : Directed vectors with a queue scoreboard and decoupled monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] prod_in = '0;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_sum_in = '0;
    logic        nan_in = 1'b0;
    logic        inf_in = 1'b0;
    logic        zero_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result_out;
    logic        overflow_out;
    logic        underflow_out;
    logic        inexact_out;

    fp_mul_normalize_round #(.MANT_W(24)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .prod_in       (prod_in),
        .sign_in       (sign_in),
        .exp_sum_in    (exp_sum_in),
        .nan_in        (nan_in),
        .inf_in        (inf_in),
        .zero_in       (zero_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_out    (result_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out),
        .inexact_out   (inexact_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] prod;
        logic        sign;
        logic [9:0]  exp;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [34:0] expect_v;   // {result, overflow, underflow, inexact}
    } vec_t;

    vec_t        vecs [0:13];
    logic [34:0] sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] stall_val;
    logic        stall_seen = 1'b0;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    initial begin
        vecs[0]  = '{48'h4000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h3F80_0000, 3'b000}};
        vecs[1]  = '{48'h9000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h4010_0000, 3'b000}};
        vecs[2]  = '{48'h4000_0040_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h3F80_0000, 3'b001}};
        vecs[3]  = '{48'h4000_00C0_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h3F80_0002, 3'b001}};
        vecs[4]  = '{48'h7FFF_FFC0_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, {32'h4000_0000, 3'b001}};
        vecs[5]  = '{48'h8000_0000_0000, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, {32'h7F80_0000, 3'b101}};
        vecs[6]  = '{48'h4000_0000_0000, 1'b1, 10'd0,   1'b0, 1'b0, 1'b0, {32'h8000_0000, 3'b011}};
        vecs[7]  = '{48'h4000_0000_0000, 1'b1, 10'd127, 1'b1, 1'b0, 1'b0, {32'h7FC0_0000, 3'b000}};
        vecs[8]  = '{48'h4000_0000_0000, 1'b1, 10'd127, 1'b0, 1'b1, 1'b0, {32'hFF80_0000, 3'b000}};
        vecs[9]  = '{48'h4000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b1, {32'h0000_0000, 3'b000}};
        vecs[10] = '{48'h9000_0000_0000, 1'b1, 10'd127, 1'b0, 1'b0, 1'b0, {32'hC010_0000, 3'b000}};
        // Rounding carry pushes exponent from 254 to 255.
        vecs[11] = '{48'h7FFF_FFC0_0000, 1'b0, 10'd254, 1'b0, 1'b0, 1'b0, {32'h7F80_0000, 3'b101}};
        vecs[12] = '{48'h4000_0000_0000, 1'b0, 10'd1,   1'b0, 1'b0, 1'b0, {32'h0080_0000, 3'b000}};
        vecs[13] = '{48'h8000_0000_0000, 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 3'b011}};
    end

    // Monitor: outputs are stable at the falling edge; a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!out_ready) begin
                if (stall_seen) chk("stall_hold", {3'b0, result_out}, {3'b0, stall_val});
                stall_val  <= result_out;
                stall_seen <= 1'b1;
            end else begin
                stall_seen <= 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {result_out, overflow_out, underflow_out, inexact_out}, 35'h0);
                    if (result_out == 32'h0 && !overflow_out && !underflow_out && !inexact_out)
                        chk("unexpected_beat_flag", 35'd1, 35'd0);
                end else begin
                    chk("beat", {result_out, overflow_out, underflow_out, inexact_out}, sb.pop_front());
                end
            end
        end else begin
            stall_seen <= 1'b0;
        end
    end

    task automatic send(input int idx);
        int budget = 200;
        in_valid   = 1'b1;
        prod_in    = vecs[idx].prod;
        sign_in    = vecs[idx].sign;
        exp_sum_in = vecs[idx].exp;
        nan_in     = vecs[idx].nan;
        inf_in     = vecs[idx].inf;
        zero_in    = vecs[idx].zero;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(vecs[idx].expect_v);
                break;
            end
            budget--;
            if (budget == 0) begin
                chk("send_timeout", 35'd1, 35'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int drain;
        #12;
        chk("reset_out_valid", {34'd0, out_valid}, 35'd0);
        chk("reset_outputs", {result_out, overflow_out, underflow_out, inexact_out}, 35'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", {34'd0, in_ready}, 35'd1);

        // Latency with an empty pipeline: two edges from acceptance to out_valid.
        send(0);
        chk("latency_edge1", {34'd0, out_valid}, 35'd0);
        @(posedge clk); #1;
        chk("latency_edge2", {34'd0, out_valid}, 35'd1);

        for (int i = 1; i < 14; i++) send(i);
        repeat (4) @(posedge clk);

        // Back-pressure: two beats fill both stages, then in_ready must drop.
        #1;
        out_ready = 1'b0;
        send(0);
        send(1);
        chk("bp_in_ready_low", {34'd0, in_ready}, 35'd0);
        fork
            begin
                send(3);
                send(4);
                send(8);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b1;
                #1;
                chk("bp_in_ready_rise", {34'd0, in_ready}, 35'd1);
            end
        join
        repeat (6) @(posedge clk);

        // Reset with both stages holding beats.
        #1;
        out_ready = 1'b0;
        send(5);
        send(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {34'd0, out_valid}, 35'd0);
        chk("midreset_result", {3'b0, result_out}, 35'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_idle", {34'd0, out_valid}, 35'd0);
        end
        send(10);
        chk("post_reset_lat1", {34'd0, out_valid}, 35'd0);
        @(posedge clk); #1;
        chk("post_reset_lat2", {34'd0, out_valid}, 35'd1);

        drain = 0;
        while (sb.size() != 0 && drain < 100) begin
            @(posedge clk);
            drain++;
        end
        #1;
        chk("scoreboard_empty", 35'(sb.size()), 35'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
